uart_tx_packetizer: RTL

- Transmit end of the UART link: takes one W_BUS-bit result bus (the MVM output vector, R*W_Y_OUT bits) over a valid/ready handshake.
- Splits the bus into N_WORDS bytes, word 0 = bits [BITS_PER_WORD-1:0] first.
- Sends each word as one UART frame on tx: start bit, data LSB first, then high stop/padding bits up to PACKET_SIZE bits.
- Sits between the MVM core output and the tx pin of the top-level.

---
 rtl/uart_tx_packetizer_if.sv | 11 +
 rtl/uart_tx_packetizer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_packetizer_if.sv
// Parallel result-bus handshake between the MVM output and the UART transmit packetizer.
interface uart_tx_packetizer_if #(
    parameter int W_BUS = 16
);
    logic [W_BUS-1:0] s_data;
    logic             s_valid;
    logic             s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/uart_tx_packetizer.sv
// Serialises one W_BUS-bit result bus into N_WORDS back-to-back UART frames on tx,
// word 0 (bus LSBs) first, each frame: start bit, data LSB first, high stop/padding.
module uart_tx_packetizer #(
    parameter int CLOCKS_PER_PULSE = 54,
    parameter int BITS_PER_WORD    = 8,
    parameter int PACKET_SIZE      = 13,
    parameter int W_BUS            = 16
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_packetizer_if.slave bus,
    output logic                tx,
    output logic                busy
);
    localparam int N_WORDS = W_BUS / BITS_PER_WORD;
    localparam int PULSE_W = $clog2(CLOCKS_PER_PULSE);
    localparam int BIT_W   = $clog2(PACKET_SIZE);
    localparam int WORD_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(PACKET_SIZE - 1);
    localparam logic [BIT_W-1:0]   DATA_LAST  = BIT_W'(BITS_PER_WORD);
    localparam logic [WORD_W-1:0]  WORD_LAST  = WORD_W'(N_WORDS - 1);

    if (W_BUS % BITS_PER_WORD != 0) begin : g_bad_bus_width
        $fatal(1, "W_BUS must be a multiple of BITS_PER_WORD");
    end
    if (PACKET_SIZE < BITS_PER_WORD + 2) begin : g_bad_packet_size
        $fatal(1, "PACKET_SIZE must hold start, data and at least one stop bit");
    end
    if (CLOCKS_PER_PULSE < 2) begin : g_bad_pulse_len
        $fatal(1, "CLOCKS_PER_PULSE must be at least 2");
    end

    typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t              state_r, state_nxt_s;
    logic [PULSE_W-1:0]  pulse_r, pulse_nxt_s;
    logic [BIT_W-1:0]    bit_r, bit_nxt_s;
    logic [WORD_W-1:0]   word_r, word_nxt_s;
    logic [W_BUS-1:0]    data_r;
    logic [BITS_PER_WORD-1:0] word_byte_s;
    logic                accept_s;
    logic                tx_r, tx_nxt_s;
    logic                busy_r, busy_nxt_s;
    logic                ready_r, ready_nxt_s;

    // Line level of frame bit idx: 0 = start, 1..BITS_PER_WORD = data LSB first, rest high.
    function automatic logic frame_bit(input logic [BITS_PER_WORD-1:0] byte_v,
                                       input logic [BIT_W-1:0] idx);
        logic [BITS_PER_WORD-1:0] shifted_v;
        logic                     level_v;
        shifted_v = byte_v >> (idx - 1'b1);
        if (idx == '0) begin
            level_v = 1'b0;
        end else if (idx <= DATA_LAST) begin
            level_v = shifted_v[0];
        end else begin
            level_v = 1'b1;
        end
        return level_v;
    endfunction

    assign accept_s   = (state_r == IDLE) && bus.s_valid && ready_r;
    assign tx         = tx_r;
    assign busy       = busy_r;
    assign bus.s_ready = ready_r;

    // State, counters, captured bus and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            pulse_r <= '0;
            bit_r   <= '0;
            word_r  <= '0;
            data_r  <= '0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pulse_r <= pulse_nxt_s;
            bit_r   <= bit_nxt_s;
            word_r  <= word_nxt_s;
            tx_r    <= tx_nxt_s;
            busy_r  <= busy_nxt_s;
            ready_r <= ready_nxt_s;
            if (accept_s) begin
                data_r <= bus.s_data;
            end else begin
                data_r <= data_r;
            end
        end
    end

    // Next state and counter advance: pulse wraps into bit, bit wraps into word.
    always_comb begin
        state_nxt_s = state_r;
        pulse_nxt_s = pulse_r;
        bit_nxt_s   = bit_r;
        word_nxt_s  = word_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = SEND;
                    pulse_nxt_s = '0;
                    bit_nxt_s   = '0;
                    word_nxt_s  = '0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: begin
                if (pulse_r != PULSE_LAST) begin
                    pulse_nxt_s = pulse_r + 1'b1;
                end else begin
                    pulse_nxt_s = '0;
                    if (bit_r != BIT_LAST) begin
                        bit_nxt_s = bit_r + 1'b1;
                    end else begin
                        bit_nxt_s = '0;
                        if (word_r != WORD_LAST) begin
                            word_nxt_s = word_r + 1'b1;
                        end else begin
                            word_nxt_s  = '0;
                            state_nxt_s = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, so tx/busy/s_ready are all flop outputs.
    always_comb begin
        word_byte_s = BITS_PER_WORD'(data_r >> (int'(word_nxt_s) * BITS_PER_WORD));
        tx_nxt_s    = 1'b1;
        busy_nxt_s  = 1'b0;
        ready_nxt_s = 1'b1;
        if (state_nxt_s == SEND) begin
            tx_nxt_s    = frame_bit(word_byte_s, bit_nxt_s);
            busy_nxt_s  = 1'b1;
            ready_nxt_s = 1'b0;
        end else begin
            tx_nxt_s    = 1'b1;
            busy_nxt_s  = 1'b0;
            ready_nxt_s = 1'b1;
        end
    end
endmodule
